// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller driving an external BCD decoder.
// Each digit gets a blanking gap, then a show window; new values are only adopted at frame start.
module seg7_scan_ctrl #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic        lamp_test,
  output logic        dec_enable,
  output logic        dec_all_on,
  output logic [3:0]  dec_bcd,
  output logic [3:0]  dig_n,
  output logic        frame_done
);

  typedef enum logic [1:0] {OFF = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK_CYC > 0) ? 16'(BLANK_CYC - 1) : 16'd0;
  localparam bit          NO_BLANK   = (BLANK_CYC == 0);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] pend_reg, disp_reg, disp_nxt;
  logic        pend_flag;
  logic        frame_end, enter_show0;
  logic [3:0]  nibble;
  logic        lz_hide;
  logic [3:0]  dig_nxt, bcd_nxt;
  logic        en_nxt, all_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OFF;
      idx   <= 2'd0;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 16'd1;
    if (!run) begin
      state_nxt = OFF;
      idx_nxt   = 2'd0;
      cnt_nxt   = 16'd0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = NO_BLANK ? SHOW : BLANK;
          idx_nxt   = 2'd0;
          cnt_nxt   = 16'd0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = 16'd0;
          end
        end
        SHOW: begin
          if (cnt == DIV_LAST) begin
            state_nxt = NO_BLANK ? SHOW : BLANK;
            idx_nxt   = idx + 2'd1;
            cnt_nxt   = 16'd0;
          end
        end
        default: begin
          state_nxt = OFF;
          idx_nxt   = 2'd0;
          cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  assign frame_end   = run && (state == SHOW) && (idx == 2'd3) && (cnt == DIV_LAST);
  // Frame start: the first cycle of digit 0, however it was reached (blank, off, or wrap from digit 3).
  assign enter_show0 = (state_nxt == SHOW) && (idx_nxt == 2'd0) && !((state == SHOW) && (idx == 2'd0));

  always_comb begin
    disp_nxt = disp_reg;
    if (enter_show0) begin
      if (load)
        disp_nxt = value;
      else if (pend_flag)
        disp_nxt = pend_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg  <= 16'h0000;
      pend_flag <= 1'b0;
      disp_reg  <= 16'h0000;
    end else begin
      disp_reg <= disp_nxt;
      if (enter_show0) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_reg  <= value;
        pend_flag <= 1'b1;
      end
    end
  end

  // Outputs are computed from next-cycle state so the registered pins match the state they belong to.
  always_comb begin
    nibble  = disp_nxt[3:0];
    lz_hide = 1'b0;
    case (idx_nxt)
      2'd0: nibble = disp_nxt[3:0];
      2'd1: begin
        nibble  = disp_nxt[7:4];
        lz_hide = (disp_nxt[15:4] == 12'd0);
      end
      2'd2: begin
        nibble  = disp_nxt[11:8];
        lz_hide = (disp_nxt[15:8] == 8'd0);
      end
      default: begin
        nibble  = disp_nxt[15:12];
        lz_hide = (disp_nxt[15:12] == 4'd0);
      end
    endcase

    dig_nxt = 4'b1111;
    en_nxt  = 1'b0;
    all_nxt = 1'b0;
    bcd_nxt = 4'd0;
    if (state_nxt == SHOW) begin
      dig_nxt = ~(4'b0001 << idx_nxt);
      bcd_nxt = nibble;
      en_nxt  = lamp_test || !(blank_lz && lz_hide);
      all_nxt = lamp_test;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_n      <= 4'b1111;
      dec_enable <= 1'b0;
      dec_all_on <= 1'b0;
      dec_bcd    <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      dig_n      <= dig_nxt;
      dec_enable <= en_nxt;
      dec_all_on <= all_nxt;
      dec_bcd    <= bcd_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: default-parameter instance driven from a vector table plus
// hand sequences, and a DIV=1/BLANK_CYC=0 instance for the back-to-back scan case.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, load, blank_lz, lamp_test;
  logic [15:0] value;
  logic        dec_enable, dec_all_on, frame_done;
  logic [3:0]  dec_bcd, dig_n;

  logic        f_reset, f_run, f_load;
  logic [15:0] f_value;
  logic        f_en, f_all, f_fd;
  logic [3:0]  f_bcd, f_dig;

  logic [10:0] main_out, fast_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic        run;
    logic        load;
    logic [15:0] value;
    logic        lz;
    logic        lt;
    logic [3:0]  dig;
    logic        en;
    logic        all;
    logic [3:0]  bcd;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [10:0] OFF_OUT = {4'b1111, 1'b0, 1'b0, 4'd0, 1'b0};

  always #5 clk = ~clk;

  seg7_scan_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .lamp_test  (lamp_test),
    .dec_enable (dec_enable),
    .dec_all_on (dec_all_on),
    .dec_bcd    (dec_bcd),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  seg7_scan_ctrl #(.DIV(1), .BLANK_CYC(0)) u_fast (
    .clk        (clk),
    .reset      (f_reset),
    .run        (f_run),
    .load       (f_load),
    .value      (f_value),
    .blank_lz   (blank_lz),
    .lamp_test  (lamp_test),
    .dec_enable (f_en),
    .dec_all_on (f_all),
    .dec_bcd    (f_bcd),
    .dig_n      (f_dig),
    .frame_done (f_fd)
  );

  assign main_out = {dig_n, dec_enable, dec_all_on, dec_bcd, frame_done};
  assign fast_out = {f_dig, f_en, f_all, f_bcd, f_fd};

  function automatic logic [10:0] pack(input logic [3:0] dig, input logic en, input logic all,
                                       input logic [3:0] bcd, input logic fd);
    return {dig, en, all, bcd, fd};
  endfunction

  task automatic addVec(input int n, input logic r, input logic ld, input logic [15:0] v,
                        input logic lz, input logic lt, input logic [3:0] dig, input logic en,
                        input logic all, input logic [3:0] bcd, input logic fd);
    vec_t t;
    t.n = n; t.run = r; t.load = ld; t.value = v; t.lz = lz; t.lt = lt;
    t.dig = dig; t.en = en; t.all = all; t.bcd = bcd; t.fd = fd;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: dig_n/en/all_on/bcd/frame_done got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    run       = v.run;
    load      = v.load;
    value     = v.value;
    blank_lz  = v.lz;
    lamp_test = v.lt;
  endtask

  task automatic expectCycles(input string name, input int n, input logic [10:0] exp);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.%0d", name, c), main_out, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; load = 1'b0; value = 16'h0; blank_lz = 1'b0; lamp_test = 1'b0;
    f_reset = 1'b1; f_run = 1'b0; f_load = 1'b0; f_value = 16'h0;

    // n, run, load, value, blank_lz, lamp_test | dig_n, en, all_on, bcd, frame_done
    addVec(1, 0, 1, 16'h1234, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hE, 1, 0, 4'd4, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hD, 1, 0, 4'd3, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hB, 1, 0, 4'd2, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'h7, 1, 0, 4'd1, 0);
    addVec(1, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 1);
    addVec(1, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hE, 1, 0, 4'd4, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hD, 1, 0, 4'd3, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(1, 1, 1, 16'h5678, 0, 0, 4'hB, 1, 0, 4'd2, 0);
    addVec(3, 1, 0, 16'h0000, 0, 0, 4'hB, 1, 0, 4'd2, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'h7, 1, 0, 4'd1, 0);
    addVec(1, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 1);
    addVec(1, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hE, 1, 0, 4'd8, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hD, 1, 0, 4'd7, 0);
    addVec(1, 1, 1, 16'h0042, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(1, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'hB, 1, 0, 4'd6, 0);
    addVec(2, 1, 0, 16'h0000, 0, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 0, 0, 4'h7, 1, 0, 4'd5, 0);
    addVec(1, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 1);
    addVec(1, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'hE, 1, 0, 4'd2, 0);
    addVec(2, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'hD, 1, 0, 4'd4, 0);
    addVec(2, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'hB, 0, 0, 4'd0, 0);
    addVec(2, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'h7, 0, 0, 4'd0, 0);
    addVec(1, 1, 1, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 1);
    addVec(1, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'hE, 1, 0, 4'd0, 0);
    addVec(2, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'hD, 0, 0, 4'd0, 0);
    addVec(2, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'hB, 0, 0, 4'd0, 0);
    addVec(2, 1, 0, 16'h0000, 1, 0, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 0, 4'h7, 0, 0, 4'd0, 0);
    addVec(1, 1, 0, 16'h0000, 1, 1, 4'hF, 0, 0, 4'd0, 1);
    addVec(1, 1, 0, 16'h0000, 1, 1, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 1, 4'hE, 1, 1, 4'd0, 0);
    addVec(2, 1, 0, 16'h0000, 1, 1, 4'hF, 0, 0, 4'd0, 0);
    addVec(4, 1, 0, 16'h0000, 1, 1, 4'hD, 1, 1, 4'd0, 0);

    $display("[TB] reset and table phase");
    expectCycles("reset_state", 2, OFF_OUT);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      for (int c = 0; c < vecs[i].n; c++) begin
        @(negedge clk);
        checkOutput($sformatf("vec%0d.%0d", i, c), main_out,
                    pack(vecs[i].dig, vecs[i].en, vecs[i].all, vecs[i].bcd, vecs[i].fd));
      end
    end

    // Reset lands in the last cycle of a SHOW window with run still high.
    $display("[TB] hand sequences");
    reset = 1'b1; run = 1'b1; load = 1'b0; blank_lz = 1'b0; lamp_test = 1'b0;
    expectCycles("reset_mid_show", 2, OFF_OUT);
    reset = 1'b0;
    expectCycles("post_reset_blank", 2, OFF_OUT | 11'b0);
    expectCycles("post_reset_disp_zero", 1, pack(4'hE, 1, 0, 4'd0, 0));

    run = 1'b0;
    expectCycles("run_low_off", 1, OFF_OUT);
    load = 1'b1; value = 16'h1111;
    expectCycles("load_in_off", 1, OFF_OUT);
    load = 1'b0; run = 1'b1;
    expectCycles("seqb_blank", 2, OFF_OUT);
    load = 1'b1; value = 16'hABCD;
    expectCycles("coincident_load", 1, pack(4'hE, 1, 0, 4'hD, 0));
    load = 1'b0;
    expectCycles("show0_abcd", 3, pack(4'hE, 1, 0, 4'hD, 0));
    expectCycles("seqb_blank1", 2, OFF_OUT);
    expectCycles("show1_abcd", 2, pack(4'hD, 1, 0, 4'hC, 0));
    run = 1'b0;
    expectCycles("run_drop_mid_show", 3, OFF_OUT);
    run = 1'b1;
    expectCycles("restart_blank", 2, OFF_OUT);
    expectCycles("restart_idx0_flag_clear", 1, pack(4'hE, 1, 0, 4'hD, 0));

    $display("[TB] DIV=1 BLANK_CYC=0 instance");
    f_reset = 1'b0; f_load = 1'b1; f_value = 16'h1234;
    @(negedge clk);
    checkOutput("fast_off", fast_out, OFF_OUT);
    f_load = 1'b0; f_run = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [1:0]  di;
      logic [10:0] exp;
      di  = 2'(k % 4);
      exp = pack(4'b1111 ^ (4'b0001 << di), 1'b1, 1'b0, 4'(4 - (k % 4)),
                 (k >= 4) && (di == 2'd0));
      @(negedge clk);
      checkOutput($sformatf("fast_scan.%0d", k), fast_out, exp);
    end
    f_reset = 1'b1;
    @(negedge clk);
    checkOutput("fast_reset_mid_scan", fast_out, OFF_OUT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
